// File: rtl/tl_host_arbiter.sv
// Round-robin sharing of one TileLink-UL device port by NumHosts hosts; A grant is combinational (zero latency)
// and held for whole Put bursts, D responses steer back by source index; backpressure passes straight through.
module tl_host_arbiter #(
  parameter int NumHosts          = 2,
  parameter int AddrWidth         = 56,
  parameter int DataWidth         = 64,
  parameter int HostSourceWidth   = 1,
  parameter int SinkWidth         = 1,
  parameter int MaxSize           = 6,
  parameter int DeviceSourceWidth = HostSourceWidth + $clog2(NumHosts)
) (
  input  logic                                       clk_i,
  input  logic                                       rst_ni,
  input  logic [NumHosts-1:0]                        host_a_valid,
  output logic [NumHosts-1:0]                        host_a_ready,
  input  logic [NumHosts-1:0][2:0]                   host_a_opcode,
  input  logic [NumHosts-1:0][2:0]                   host_a_param,
  input  logic [NumHosts-1:0][3:0]                   host_a_size,
  input  logic [NumHosts-1:0][HostSourceWidth-1:0]   host_a_source,
  input  logic [NumHosts-1:0][AddrWidth-1:0]         host_a_address,
  input  logic [NumHosts-1:0][DataWidth/8-1:0]       host_a_mask,
  input  logic [NumHosts-1:0]                        host_a_corrupt,
  input  logic [NumHosts-1:0][DataWidth-1:0]         host_a_data,
  output logic [NumHosts-1:0]                        host_d_valid,
  input  logic [NumHosts-1:0]                        host_d_ready,
  output logic [2:0]                                 host_d_opcode,
  output logic [2:0]                                 host_d_param,
  output logic [3:0]                                 host_d_size,
  output logic [HostSourceWidth-1:0]                 host_d_source,
  output logic [SinkWidth-1:0]                       host_d_sink,
  output logic                                       host_d_denied,
  output logic                                       host_d_corrupt,
  output logic [DataWidth-1:0]                       host_d_data,
  output logic [NumHosts-1:0]                        host_b_valid,
  output logic [NumHosts-1:0]                        host_c_ready,
  output logic [NumHosts-1:0]                        host_e_ready,
  output logic                                       device_a_valid,
  input  logic                                       device_a_ready,
  output logic [2:0]                                 device_a_opcode,
  output logic [2:0]                                 device_a_param,
  output logic [3:0]                                 device_a_size,
  output logic [DeviceSourceWidth-1:0]               device_a_source,
  output logic [AddrWidth-1:0]                       device_a_address,
  output logic [DataWidth/8-1:0]                     device_a_mask,
  output logic                                       device_a_corrupt,
  output logic [DataWidth-1:0]                       device_a_data,
  input  logic                                       device_d_valid,
  output logic                                       device_d_ready,
  input  logic [2:0]                                 device_d_opcode,
  input  logic [2:0]                                 device_d_param,
  input  logic [3:0]                                 device_d_size,
  input  logic [DeviceSourceWidth-1:0]               device_d_source,
  input  logic [SinkWidth-1:0]                       device_d_sink,
  input  logic                                       device_d_denied,
  input  logic                                       device_d_corrupt,
  input  logic [DataWidth-1:0]                       device_d_data,
  output logic                                       device_b_ready,
  output logic                                       device_c_valid,
  output logic                                       device_e_valid
);

  localparam int IdxW     = $clog2(NumHosts);
  localparam int BeatSize = $clog2(DataWidth / 8);
  localparam int BlW      = (MaxSize > BeatSize) ? MaxSize - BeatSize : 1;

  if (NumHosts < 2) begin : g_chk_hosts
    $fatal(1, "tl_host_arbiter: NumHosts must be at least 2");
  end
  if (DeviceSourceWidth < HostSourceWidth + IdxW) begin : g_chk_src
    $fatal(1, "tl_host_arbiter: DeviceSourceWidth too narrow for host index");
  end
  if (MaxSize < BeatSize) begin : g_chk_size
    $fatal(1, "tl_host_arbiter: MaxSize smaller than one beat");
  end

  typedef enum logic {Idle, Locked} state_e;

  state_e            state, state_next;
  logic [IdxW-1:0]   rr_ptr, owner, winner, cand, sel;
  logic [BlW-1:0]    beats_left, sel_beats_m1;
  logic              accept;
  logic [IdxW-1:0]   d_idx;
  logic              d_hit;

  // Only Put bursts span several beats; the result is the beat count minus one.
  function automatic logic [BlW-1:0] beats_m1(input logic [2:0] op, input logic [3:0] size);
    int n;
    n = 0;
    if ((op == 3'd0 || op == 3'd1) && int'(size) > BeatSize) begin
      n = (1 << (int'(size) - BeatSize)) - 1;
    end
    return BlW'(n);
  endfunction

  always_comb begin
    winner = rr_ptr;
    cand   = '0;
    for (int i = NumHosts - 1; i >= 0; i--) begin
      cand = (int'(rr_ptr) + i >= NumHosts) ? IdxW'(int'(rr_ptr) + i - NumHosts)
                                            : IdxW'(int'(rr_ptr) + i);
      if (host_a_valid[cand]) winner = cand;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= Idle;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      Idle:    if (accept && sel_beats_m1 != '0) state_next = Locked;
      Locked:  if (accept && beats_left == '0)   state_next = Idle;
      default: state_next = Idle;
    endcase
  end

  always_comb begin
    sel               = (state == Locked) ? owner : winner;
    device_a_valid    = (state == Locked) ? host_a_valid[owner] : |host_a_valid;
    host_a_ready      = '0;
    host_a_ready[sel] = device_a_ready;
    device_a_opcode   = host_a_opcode[sel];
    device_a_param    = host_a_param[sel];
    device_a_size     = host_a_size[sel];
    device_a_address  = host_a_address[sel];
    device_a_mask     = host_a_mask[sel];
    device_a_corrupt  = host_a_corrupt[sel];
    device_a_data     = host_a_data[sel];
    device_a_source   = '0;
    device_a_source[HostSourceWidth-1:0]        = host_a_source[sel];
    device_a_source[DeviceSourceWidth-1 -: IdxW] = sel;
  end

  assign accept       = device_a_valid & device_a_ready;
  assign sel_beats_m1 = beats_m1(host_a_opcode[sel], host_a_size[sel]);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr     <= '0;
      owner      <= '0;
      beats_left <= '0;
    end else if (accept) begin
      if (state == Idle) begin
        rr_ptr <= (int'(winner) == NumHosts - 1) ? '0 : winner + 1'b1;
        if (sel_beats_m1 != '0) begin
          owner      <= winner;
          beats_left <= sel_beats_m1 - 1'b1;
        end
      end else if (beats_left != '0) begin
        beats_left <= beats_left - 1'b1;
      end
    end
  end

  // Responses for a nonexistent host are swallowed so the device never stalls.
  assign d_idx = device_d_source[DeviceSourceWidth-1 -: IdxW];
  assign d_hit = (int'(d_idx) < NumHosts);

  always_comb begin
    host_d_valid   = '0;
    device_d_ready = 1'b1;
    if (d_hit) begin
      host_d_valid[d_idx] = device_d_valid;
      device_d_ready      = host_d_ready[d_idx];
    end
  end

  assign host_d_opcode  = device_d_opcode;
  assign host_d_param   = device_d_param;
  assign host_d_size    = device_d_size;
  assign host_d_source  = device_d_source[HostSourceWidth-1:0];
  assign host_d_sink    = device_d_sink;
  assign host_d_denied  = device_d_denied;
  assign host_d_corrupt = device_d_corrupt;
  assign host_d_data    = device_d_data;

  assign host_b_valid   = '0;
  assign host_c_ready   = '1;
  assign host_e_ready   = '1;
  assign device_b_ready = 1'b1;
  assign device_c_valid = 1'b0;
  assign device_e_valid = 1'b0;

  always @(posedge clk_i) begin
    if (rst_ni && device_d_valid) begin
      assert (d_hit) else $warning("tl_host_arbiter: D response for nonexistent host %0d dropped", d_idx);
    end
  end

endmodule

// File: tb/tb_tl_host_arbiter.sv
// Bench for tl_host_arbiter with three hosts: D routing table, hand-built burst/reset sequences, random run vs model.
module tb_tl_host_arbiter;
  localparam int N = 3;
  localparam int AW = 56;
  localparam int DW = 64;
  localparam logic [2:0] OP_PUTF = 3'd0;
  localparam logic [2:0] OP_PUTP = 3'd1;
  localparam logic [2:0] OP_GET  = 3'd4;
  localparam logic [2:0] OP_ACKD = 3'd1;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic [N-1:0] host_a_valid, host_a_ready;
  logic [N-1:0][2:0] host_a_opcode, host_a_param;
  logic [N-1:0][3:0] host_a_size;
  logic [N-1:0][0:0] host_a_source;
  logic [N-1:0][AW-1:0] host_a_address;
  logic [N-1:0][DW/8-1:0] host_a_mask;
  logic [N-1:0] host_a_corrupt;
  logic [N-1:0][DW-1:0] host_a_data;
  logic [N-1:0] host_d_valid, host_d_ready;
  logic [2:0] host_d_opcode, host_d_param;
  logic [3:0] host_d_size;
  logic [0:0] host_d_source, host_d_sink;
  logic host_d_denied, host_d_corrupt;
  logic [DW-1:0] host_d_data;
  logic [N-1:0] host_b_valid, host_c_ready, host_e_ready;
  logic device_a_valid, device_a_ready;
  logic [2:0] device_a_opcode, device_a_param;
  logic [3:0] device_a_size;
  logic [2:0] device_a_source;
  logic [AW-1:0] device_a_address;
  logic [DW/8-1:0] device_a_mask;
  logic device_a_corrupt;
  logic [DW-1:0] device_a_data;
  logic device_d_valid, device_d_ready;
  logic [2:0] device_d_opcode, device_d_param;
  logic [3:0] device_d_size;
  logic [2:0] device_d_source;
  logic [0:0] device_d_sink;
  logic device_d_denied, device_d_corrupt;
  logic [DW-1:0] device_d_data;
  logic device_b_ready, device_c_valid, device_e_valid;

  tl_host_arbiter #(.NumHosts(N)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .host_a_valid(host_a_valid), .host_a_ready(host_a_ready),
    .host_a_opcode(host_a_opcode), .host_a_param(host_a_param), .host_a_size(host_a_size),
    .host_a_source(host_a_source), .host_a_address(host_a_address), .host_a_mask(host_a_mask),
    .host_a_corrupt(host_a_corrupt), .host_a_data(host_a_data),
    .host_d_valid(host_d_valid), .host_d_ready(host_d_ready),
    .host_d_opcode(host_d_opcode), .host_d_param(host_d_param), .host_d_size(host_d_size),
    .host_d_source(host_d_source), .host_d_sink(host_d_sink), .host_d_denied(host_d_denied),
    .host_d_corrupt(host_d_corrupt), .host_d_data(host_d_data),
    .host_b_valid(host_b_valid), .host_c_ready(host_c_ready), .host_e_ready(host_e_ready),
    .device_a_valid(device_a_valid), .device_a_ready(device_a_ready),
    .device_a_opcode(device_a_opcode), .device_a_param(device_a_param), .device_a_size(device_a_size),
    .device_a_source(device_a_source), .device_a_address(device_a_address), .device_a_mask(device_a_mask),
    .device_a_corrupt(device_a_corrupt), .device_a_data(device_a_data),
    .device_d_valid(device_d_valid), .device_d_ready(device_d_ready),
    .device_d_opcode(device_d_opcode), .device_d_param(device_d_param), .device_d_size(device_d_size),
    .device_d_source(device_d_source), .device_d_sink(device_d_sink), .device_d_denied(device_d_denied),
    .device_d_corrupt(device_d_corrupt), .device_d_data(device_d_data),
    .device_b_ready(device_b_ready), .device_c_valid(device_c_valid), .device_e_valid(device_e_valid)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    host_a_valid = '0; host_a_opcode = '0; host_a_param = '0; host_a_size = '0;
    host_a_source = '0; host_a_address = '0; host_a_mask = '1; host_a_corrupt = '0; host_a_data = '0;
    host_d_ready = '0; device_a_ready = 1'b0;
    device_d_valid = 1'b0; device_d_opcode = '0; device_d_param = '0; device_d_size = '0;
    device_d_source = '0; device_d_sink = '0; device_d_denied = 1'b0; device_d_corrupt = 1'b0;
    device_d_data = '0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    clear_inputs();
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic drive_host(input int h, input logic v, input logic [2:0] op, input logic [3:0] sz,
                            input logic s, input logic [AW-1:0] addr, input logic [DW-1:0] dat);
    host_a_valid[h] = v; host_a_opcode[h] = op; host_a_size[h] = sz;
    host_a_source[h] = s; host_a_address[h] = addr; host_a_data[h] = dat;
  endtask

  function automatic int tl_beats(input logic [2:0] op, input logic [3:0] size);
    if ((op == OP_PUTF || op == OP_PUTP) && size > 4'd3) return 1 << (int'(size) - 3);
    return 1;
  endfunction

  typedef struct {
    logic dv; logic [2:0] src; logic [2:0] hrdy;
    logic [2:0] e_hv; logic e_dr; logic e_hsrc;
  } dvec_t;
  dvec_t dtab [7];

  // Random-run state: per-host traffic generator and arbiter reference.
  int h_left [N];
  bit h_started [N];
  int m_ptr, m_owner, m_left, g;
  logic exp_valid, acc;
  logic [2:0] exp_rdy, exp_hv;
  logic exp_dr;
  int didx;

  initial begin
    rst_ni = 1'b0;
    clear_inputs();
    dtab[0] = '{1'b1, 3'b000, 3'b001, 3'b001, 1'b1, 1'b0};
    dtab[1] = '{1'b1, 3'b011, 3'b101, 3'b010, 1'b0, 1'b1};
    dtab[2] = '{1'b1, 3'b101, 3'b100, 3'b100, 1'b1, 1'b1};
    dtab[3] = '{1'b1, 3'b111, 3'b000, 3'b000, 1'b1, 1'b1};
    dtab[4] = '{1'b0, 3'b010, 3'b010, 3'b000, 1'b1, 1'b0};
    dtab[5] = '{1'b1, 3'b110, 3'b111, 3'b000, 1'b1, 1'b0};
    dtab[6] = '{1'b0, 3'b100, 3'b000, 3'b000, 1'b0, 1'b0};

    // Reset state and tie-offs
    @(negedge clk_i); #1;
    chk("rst_a_valid", device_a_valid, 0);
    chk("rst_d_valid", host_d_valid, 0);
    chk("tie_b", {host_b_valid, device_c_valid, device_e_valid}, 0);
    chk("tie_ce", {host_c_ready, host_e_ready, device_b_ready}, 7'h7f);
    rst_ni = 1'b1;

    // D routing table
    for (int i = 0; i < 7; i++) begin
      @(negedge clk_i);
      device_d_valid = dtab[i].dv; device_d_source = dtab[i].src; host_d_ready = dtab[i].hrdy;
      device_d_opcode = OP_ACKD; device_d_data = 64'hD00D_0000 + 64'(i); device_d_size = 4'd3;
      #1;
      chk($sformatf("dtab%0d_hv", i), host_d_valid, dtab[i].e_hv);
      chk($sformatf("dtab%0d_dr", i), device_d_ready, dtab[i].e_dr);
      chk($sformatf("dtab%0d_src", i), host_d_source, dtab[i].e_hsrc);
      chk($sformatf("dtab%0d_dat", i), host_d_data, 64'hD00D_0000 + 64'(i));
      chk($sformatf("dtab%0d_op", i), {host_d_opcode, host_d_size}, {OP_ACKD, 4'd3});
    end

    // Two hosts issuing Gets back to back alternate
    do_reset();
    device_a_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_i);
      drive_host(0, 1'b1, OP_GET, 4'd3, 1'b1, 56'h100, 64'h0);
      drive_host(1, 1'b1, OP_GET, 4'd3, 1'b0, 56'h200, 64'h0);
      #1;
      chk($sformatf("alt%0d_rdy", k), host_a_ready, (k % 2 == 0) ? 3'b001 : 3'b010);
      chk($sformatf("alt%0d_src", k), device_a_source, (k % 2 == 0) ? 3'b001 : 3'b010);
    end

    // 4-beat Put holds the grant against a competing Get
    do_reset();
    device_a_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk_i);
      drive_host(0, k <= 4, OP_PUTF, 4'd5, 1'b0, 56'h1000, 64'hA0 + 64'(k));
      drive_host(1, 1'b1, OP_GET, 4'd3, 1'b1, 56'h2000, 64'h0);
      #1;
      if (k <= 4) begin
        chk($sformatf("burst%0d_rdy", k), host_a_ready, 3'b001);
        chk($sformatf("burst%0d_src", k), device_a_source, 3'b000);
        chk($sformatf("burst%0d_dat", k), device_a_data, 64'hA0 + 64'(k));
      end else begin
        chk("burst_after_rdy", host_a_ready, 3'b010);
        chk("burst_after_src", device_a_source, 3'b011);
      end
    end

    // Owner drops valid mid-burst; lock must hold
    do_reset();
    device_a_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk_i);
      drive_host(0, (k <= 2) || (k == 6) || (k == 7), OP_PUTF, 4'd5, 1'b0, 56'h3000, 64'h0);
      drive_host(1, 1'b1, OP_GET, 4'd3, 1'b1, 56'h4000, 64'h0);
      #1;
      if (k >= 3 && k <= 5) begin
        chk($sformatf("gap%0d_valid", k), device_a_valid, 0);
        chk($sformatf("gap%0d_rdy1", k), host_a_ready & 3'b110, 0);
      end else if (k == 8) begin
        chk("gap_after_rdy", host_a_ready, 3'b010);
        chk("gap_after_src", device_a_source, 3'b011);
      end else begin
        chk($sformatf("gap%0d_rdy", k), host_a_ready & host_a_valid, 3'b001);
      end
    end

    // D backpressure from host 1 while A traffic continues
    do_reset();
    device_a_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      drive_host(0, 1'b1, OP_GET, 4'd3, 1'b0, 56'h10, 64'h0);
      device_d_valid = 1'b1; device_d_source = 3'b010; device_d_opcode = OP_ACKD;
      host_d_ready = (k < 2) ? 3'b101 : 3'b111;
      #1;
      chk($sformatf("dbp%0d_dr", k), device_d_ready, k >= 2);
      chk($sformatf("dbp%0d_hv", k), host_d_valid, 3'b010);
      chk($sformatf("dbp%0d_src", k), host_d_source, 0);
      chk($sformatf("dbp%0d_arez", k), host_a_ready, 3'b001);
    end

    // Three hosts: grant order wraps at NumHosts
    do_reset();
    device_a_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      for (int h = 0; h < N; h++) drive_host(h, 1'b1, OP_GET, 4'd2, h[0], AW'(h), 64'h0);
      #1;
      chk($sformatf("wrap%0d_rdy", k), host_a_ready, 3'b001 << (k % 3));
      chk($sformatf("wrap%0d_src", k), device_a_source, {2'((k % 3)), 1'((k % 3) & 1)});
    end

    // Asynchronous reset mid-burst
    do_reset();
    device_a_ready = 1'b1;
    @(negedge clk_i);
    drive_host(0, 1'b1, OP_PUTF, 4'd5, 1'b0, 56'h5000, 64'h0);
    #1;
    chk("mrst_beat1", host_a_ready, 3'b001);
    @(negedge clk_i);
    rst_ni = 1'b0;
    drive_host(0, 1'b0, OP_PUTF, 4'd5, 1'b0, 56'h5000, 64'h0);
    drive_host(1, 1'b1, OP_GET, 4'd3, 1'b1, 56'h6000, 64'h0);
    #1;
    chk("mrst_during_src", device_a_source, 3'b011);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    chk("mrst_after_rdy", host_a_ready, 3'b010);
    chk("mrst_after_src", device_a_source, 3'b011);

    // Random traffic against the reference model
    do_reset();
    m_ptr = 0; m_owner = -1; m_left = 0;
    for (int h = 0; h < N; h++) begin h_left[h] = 0; h_started[h] = 0; end
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(negedge clk_i);
      for (int h = 0; h < N; h++) begin
        if (h_left[h] == 0) begin
          if ($urandom_range(0, 1) == 1) begin
            case ($urandom_range(0, 2))
              0: host_a_opcode[h] = OP_GET;
              1: host_a_opcode[h] = OP_PUTF;
              default: host_a_opcode[h] = OP_PUTP;
            endcase
            host_a_size[h] = 4'($urandom_range(0, 6));
            host_a_source[h] = 1'($urandom_range(0, 1));
            host_a_address[h] = AW'({$urandom, $urandom});
            host_a_data[h] = {$urandom, $urandom};
            h_left[h] = tl_beats(host_a_opcode[h], host_a_size[h]);
            h_started[h] = 0;
            host_a_valid[h] = 1'b1;
          end else begin
            host_a_valid[h] = 1'b0;
          end
        end else if (h_started[h]) begin
          host_a_valid[h] = ($urandom_range(0, 3) != 0);
        end
      end
      device_a_ready = ($urandom_range(0, 3) != 0);
      device_d_valid = 1'($urandom_range(0, 1));
      device_d_source = 3'($urandom_range(0, 5));
      host_d_ready = 3'($urandom_range(0, 7));
      device_d_data = {$urandom, $urandom};
      #1;
      g = -1;
      if (m_owner >= 0) begin
        g = m_owner;
        exp_valid = host_a_valid[m_owner];
      end else begin
        for (int k = N - 1; k >= 0; k--) if (host_a_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        exp_valid = (g >= 0);
      end
      acc = exp_valid && device_a_ready;
      exp_rdy = '0;
      if (acc) exp_rdy[g] = 1'b1;
      chk("rnd_a_valid", device_a_valid, exp_valid);
      chk("rnd_a_ready", host_a_ready & host_a_valid, exp_rdy);
      if (exp_valid) begin
        chk("rnd_a_src", device_a_source, {2'(g), host_a_source[g]});
        chk("rnd_a_addr", device_a_address, host_a_address[g]);
        chk("rnd_a_data", device_a_data, host_a_data[g]);
        chk("rnd_a_op", {device_a_opcode, device_a_size}, {host_a_opcode[g], host_a_size[g]});
      end
      didx = int'(device_d_source[2:1]);
      exp_hv = '0;
      if (didx < N) exp_hv[didx] = device_d_valid;
      exp_dr = (didx < N) ? host_d_ready[didx] : 1'b1;
      chk("rnd_d_valid", host_d_valid, exp_hv);
      chk("rnd_d_ready", device_d_ready, exp_dr);
      chk("rnd_d_src", host_d_source, device_d_source[0]);
      if (acc) begin
        if (m_owner >= 0) begin
          m_left--;
          if (m_left == 0) m_owner = -1;
        end else begin
          m_ptr = (g + 1) % N;
          if (tl_beats(host_a_opcode[g], host_a_size[g]) > 1) begin
            m_owner = g;
            m_left = tl_beats(host_a_opcode[g], host_a_size[g]) - 1;
          end
        end
        h_left[g]--;
        h_started[g] = 1;
        host_a_data[g] = {$urandom, $urandom};
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tl_host_arbiter.md
Name: tl_host_arbiter

Overview:
Shares one TileLink-UL device port, typically the host side of the size downsizer, between NumHosts TileLink hosts.
- A channel: round-robin arbitration, with a grant held for the full multi-beat Put burst.
- Requests are tagged by prepending the host index to the source.
- D channel: responses are steered back to the owning host by that index.
- Channels B/C/E are unused: B is tied off, C/E are accepted and dropped.

Parameters:
NumHosts, 2, number of host ports (>=2)
AddrWidth, 56, address width
DataWidth, 64, data width in bits; BeatSize = log2(DataWidth/8)
HostSourceWidth, 1, source width on each host port
SinkWidth, 1, sink width (passed through, unused)
MaxSize, 6, largest legal log2 transfer size
DeviceSourceWidth, HostSourceWidth+IdxW, device source width; IdxW = clog2(NumHosts)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; one clock; reset is asynchronous and active-low
host_a_valid  in  NumHosts  per-host A valid
host_a_ready  out  NumHosts  per-host A ready
host_a  in  NumHosts x A-payload  opcode, param, size, source, address, mask, corrupt, data
host_d_valid  out  NumHosts  per-host D valid
host_d_ready  in  NumHosts  per-host D ready
host_d  out  D-payload  shared D payload; source carries HostSourceWidth bits
host_b_valid  out  NumHosts  tied 0
host_c_ready, host_e_ready  out  NumHosts  tied 1
device_a_valid  out  1  A valid to device
device_a_ready  in  1  A ready from device
device_a  out  A-payload  source is {index, host source}
device_d_valid  in  1  D valid from device
device_d_ready  out  1  D ready to device
device_d  in  D-payload  response
device_b_ready  out  1  tied 1
device_c_valid, device_e_valid  out  1  tied 0

Behaviour:
Reset state:
- State=Idle, rr_ptr=0, beats_left=0, owner=0.
- device_a_valid=0 and all host_d_valid=0 while no input is valid.

Burst length:
- beats(size) = 2^(size-BeatSize) for PutFullData/PutPartialData when size>BeatSize; otherwise 1. Get is always 1 beat.
- beats_left is MaxSize-BeatSize bits wide, stored as beats-1.

Idle:
- Grant is combinational, with no bubble: winner = first valid host scanning rr_ptr, rr_ptr+1, … modulo NumHosts.
- device_a_valid = |host_a_valid; device_a = host_a[winner] with source {winner, host_a[winner].source}.
- host_a_ready[winner] = device_a_ready; all other host_a_ready = 0.
- On an accepted beat (valid&ready): rr_ptr <= winner+1 (wraps at NumHosts, not at 2^IdxW).
- If the accepted beat's beats>1: owner <= winner, beats_left <= beats-2, State <= Locked.

Locked:
- Only owner is forwarded; other hosts see ready=0.
- Owner dropping valid mid-burst keeps the lock. No timeout.
- Each accepted beat: if beats_left==0 then State <= Idle, else beats_left-1.
- First arbitration after the burst happens the cycle after the last beat. No extra bubble.

Payload:
- device_a is fully combinational from the selected host.
- Non-selected host payloads are ignored (may be X).

D channel:
- idx = device_d.source[DeviceSourceWidth-1 -: IdxW].
- host_d_valid[idx] = device_d_valid; device_d_ready = host_d_ready[idx].
- host_d = device_d with source = low HostSourceWidth bits.
- If idx>=NumHosts: device_d_ready=1, no host_d_valid asserted (response dropped); simulation assertion fires.
- D is independent of A; simultaneous A grant and D response both proceed.

Reset mid-burst:
- Returns to Idle immediately, rr_ptr=0. The partial burst is the upstream reset domain's responsibility.

Parameter checks (elaboration $fatal):
- NumHosts<2.
- DeviceSourceWidth < HostSourceWidth+IdxW.
- MaxSize<BeatSize.

Test Plan:
- Hosts 0 and 1 issue Get size 3 every cycle, device_a_ready=1 -> device_a.source alternates {0,s},{1,s},{0,s}…; each host is accepted every 2nd cycle.
- Host 0 PutFullData size 5 (4 beats), host 1 Get in the same cycle -> 4 consecutive host-0 beats with source {0,s}, then host-1 Get on cycle 5; host_a_ready[1]=0 cycles 1–4.
- Host 0 drops valid for 3 cycles after beat 2 of a 4-beat Put while host 1 is valid -> no host-1 grant until host 0 completes beat 4.
- device_d source {1,0} AccessAckData, host_d_ready[1]=0 for 2 cycles -> device_d_ready=0 those cycles; host_d_valid=2'b10, host_d.source=0.
- NumHosts=3, all valid with Get -> grant order 0,1,2,0 (rr_ptr wraps at 3); device_d source index 3 -> accepted, no host_d_valid.
- Assert rst_ni low mid-burst (beats_left=2) -> next cycle Idle; host 1 is granted immediately after reset release if host 0 is idle.
